// File: rtl/acc_arbiter.sv
// Two-requester burst accumulator with round-robin arbitration.
// A granted requester streams len samples; the block reports their sum.
module acc_arbiter #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [LEN_W-1:0]  len0,
  input  logic [DATA_W-1:0] din0,
  input  logic              din0_valid,
  output logic              din0_ready,
  input  logic              req1,
  input  logic [LEN_W-1:0]  len1,
  input  logic [DATA_W-1:0] din1,
  input  logic              din1_valid,
  output logic              din1_ready,
  output logic [DATA_W-1:0] res,
  output logic              res_valid,
  output logic              res_id,
  output logic              ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              owner;
  logic              last;
  logic              ovf_b;
  logic [LEN_W-1:0]  cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] din_s;
  logic [LEN_W-1:0]  len_s;
  logic              din_v;
  logic              beat;
  logic              gnt_v;
  logic              gnt_id;
  logic              last_beat;

  // Tie goes to whoever was not granted last.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = 1'b0;
    if (req0 && req1) begin
      gnt_v  = 1'b1;
      gnt_id = ~last;
    end else if (req0) begin
      gnt_v  = 1'b1;
      gnt_id = 1'b0;
    end else if (req1) begin
      gnt_v  = 1'b1;
      gnt_id = 1'b1;
    end
  end

  assign len_s     = gnt_id ? len1 : len0;
  assign din_s     = owner ? din1 : din0;
  assign din_v     = owner ? din1_valid : din0_valid;
  assign beat      = (state == RUN) && din_v;
  assign last_beat = beat && (cnt == LEN_W'(1));
  assign sum       = {1'b0, acc} + {1'b0, din_s};

  assign din0_ready = (state == RUN) && !owner;
  assign din1_ready = (state == RUN) && owner;
  assign res_valid  = (state == DONE);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (gnt_v)
          state_nx = (len_s == '0) ? DONE : RUN;
      end
      RUN: begin
        if (last_beat)
          state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner  <= 1'b0;
      last   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      ovf_b  <= 1'b0;
      res    <= '0;
      res_id <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_v) begin
            owner <= gnt_id;
            last  <= gnt_id;
            cnt   <= len_s;
            acc   <= '0;
            ovf_b <= 1'b0;
            // Empty burst reports straight away.
            if (len_s == '0) begin
              res    <= '0;
              res_id <= gnt_id;
              ovf    <= 1'b0;
            end
          end
        end
        RUN: begin
          if (beat) begin
            acc   <= sum[DATA_W-1:0];
            cnt   <= cnt - 1'b1;
            ovf_b <= ovf_b | sum[DATA_W];
            if (last_beat) begin
              res    <= sum[DATA_W-1:0];
              res_id <= owner;
              ovf    <= ovf_b | sum[DATA_W];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_arbiter.sv
// Directed bench for acc_arbiter.
// Inputs change just after posedge; outputs sampled on negedge.
module tb_acc_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [7:0]  len0, len1;
  logic [15:0] din0, din1;
  logic        din0_valid, din1_valid;
  logic        din0_ready, din1_ready;
  logic [15:0] res;
  logic        res_valid, res_id, ovf, busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  acc_arbiter #(.DATA_W(16), .LEN_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .len0       (len0),
    .din0       (din0),
    .din0_valid (din0_valid),
    .din0_ready (din0_ready),
    .req1       (req1),
    .len1       (len1),
    .din1       (din1),
    .din1_valid (din1_valid),
    .din1_ready (din1_ready),
    .res        (res),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .ovf        (ovf),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".res_valid"}, 32'(res_valid), 0);
    chk({tag, ".din0_ready"}, 32'(din0_ready), 0);
    chk({tag, ".din1_ready"}, 32'(din1_ready), 0);
  endtask

  initial begin
    reset = 1'b1;
    req0 = 0; req1 = 0; len0 = 0; len1 = 0;
    din0 = 0; din1 = 0; din0_valid = 0; din1_valid = 0;

    // reset held two cycles
    nxt(); smp();
    chk_idle("rst1");
    chk("rst1.res", 32'(res), 0);
    chk("rst1.res_id", 32'(res_id), 0);
    chk("rst1.ovf", 32'(ovf), 0);
    nxt(); smp();
    chk_idle("rst2");
    reset = 1'b0;
    nxt(); smp();
    chk("noreq1.busy", 32'(busy), 0);
    nxt(); smp();
    chk("noreq2.busy", 32'(busy), 0);

    // tie: requester 0 first, requester 1 rearbitrated after
    nxt(); req0 = 1; req1 = 1; len0 = 2; len1 = 2; smp();
    chk("tie.c0.busy", 32'(busy), 0);
    nxt(); din0 = 5; din0_valid = 1; din1 = 7; din1_valid = 1; smp();
    chk("tie.c1.busy", 32'(busy), 1);
    chk("tie.c1.rdy0", 32'(din0_ready), 1);
    chk("tie.c1.rdy1", 32'(din1_ready), 0);
    nxt(); smp();
    chk("tie.c2.rdy1", 32'(din1_ready), 0);
    chk("tie.c2.res_valid", 32'(res_valid), 0);
    nxt(); smp();
    chk("tie.d0.res_valid", 32'(res_valid), 1);
    chk("tie.d0.res", 32'(res), 10);
    chk("tie.d0.res_id", 32'(res_id), 0);
    chk("tie.d0.ovf", 32'(ovf), 0);
    chk("tie.d0.rdy1", 32'(din1_ready), 0);
    nxt(); smp();
    chk("tie.idle.busy", 32'(busy), 0);
    chk("tie.idle.res_valid", 32'(res_valid), 0);
    chk("tie.idle.res", 32'(res), 10);
    nxt(); req0 = 0; req1 = 0; smp();
    chk("tie.b1.rdy1", 32'(din1_ready), 1);
    chk("tie.b1.rdy0", 32'(din0_ready), 0);
    nxt(); smp();
    nxt(); din0_valid = 0; din1_valid = 0; smp();
    chk("tie.d1.res_valid", 32'(res_valid), 1);
    chk("tie.d1.res", 32'(res), 14);
    chk("tie.d1.res_id", 32'(res_id), 1);
    nxt(); smp();
    chk("tie.post.res_valid", 32'(res_valid), 0);
    chk("tie.post.res", 32'(res), 14);
    chk("tie.post.busy", 32'(busy), 0);

    // len 4, samples 1..4 continuous
    nxt(); req0 = 1; len0 = 4; smp();
    chk("seq.t.busy", 32'(busy), 0);
    nxt(); req0 = 0; din0 = 1; din0_valid = 1; smp();
    chk("seq.b1.rdy0", 32'(din0_ready), 1);
    nxt(); din0 = 2; smp();
    nxt(); din0 = 3; smp();
    nxt(); din0 = 4; smp();
    chk("seq.b4.res_valid", 32'(res_valid), 0);
    nxt(); din0_valid = 0; smp();
    chk("seq.d.res_valid", 32'(res_valid), 1);
    chk("seq.d.res", 32'(res), 10);
    chk("seq.d.res_id", 32'(res_id), 0);
    chk("seq.d.ovf", 32'(ovf), 0);
    chk("seq.d.rdy0", 32'(din0_ready), 0);
    nxt(); smp();
    chk("seq.post.res_valid", 32'(res_valid), 0);
    chk("seq.post.busy", 32'(busy), 0);

    // carry-out sets ovf; next clean burst clears it
    nxt(); req0 = 1; len0 = 2; smp();
    nxt(); req0 = 0; din0 = 16'hFFFF; din0_valid = 1; smp();
    nxt(); din0 = 16'h0002; smp();
    nxt(); din0_valid = 0; smp();
    chk("ovf.d.res_valid", 32'(res_valid), 1);
    chk("ovf.d.res", 32'(res), 32'h0001);
    chk("ovf.d.ovf", 32'(ovf), 1);
    nxt(); smp();
    chk("ovf.hold", 32'(ovf), 1);
    nxt(); req0 = 1; len0 = 1; smp();
    nxt(); req0 = 0; din0 = 3; din0_valid = 1; smp();
    nxt(); din0_valid = 0; smp();
    chk("ovf2.res_valid", 32'(res_valid), 1);
    chk("ovf2.res", 32'(res), 3);
    chk("ovf2.ovf", 32'(ovf), 0);

    // requester 1, len 3 with single-cycle gaps between beats
    nxt(); req1 = 1; len1 = 3; smp();
    nxt(); req1 = 0; din1 = 1; din1_valid = 1; smp();
    chk("gap.c1.rdy1", 32'(din1_ready), 1);
    nxt(); din1_valid = 0; smp();
    chk("gap.c2.rdy1", 32'(din1_ready), 1);
    nxt(); din1_valid = 1; smp();
    nxt(); din1_valid = 0; smp();
    chk("gap.c4.res_valid", 32'(res_valid), 0);
    nxt(); din1_valid = 1; smp();
    chk("gap.c5.res_valid", 32'(res_valid), 0);
    nxt(); din1_valid = 0; smp();
    chk("gap.d.res_valid", 32'(res_valid), 1);
    chk("gap.d.res", 32'(res), 3);
    chk("gap.d.res_id", 32'(res_id), 1);

    // reset mid-burst aborts it
    nxt(); req0 = 1; len0 = 4; smp();
    nxt(); req0 = 0; din0 = 9; din0_valid = 1; smp();
    chk("abort.run.busy", 32'(busy), 1);
    nxt(); smp();
    nxt(); reset = 1; smp();
    nxt(); reset = 0; din0_valid = 0; smp();
    chk_idle("abort");
    chk("abort.res", 32'(res), 0);
    chk("abort.res_id", 32'(res_id), 0);
    chk("abort.ovf", 32'(ovf), 0);
    nxt(); smp();
    chk("abort.later.res_valid", 32'(res_valid), 0);

    // zero-length burst
    nxt(); req0 = 1; len0 = 0; smp();
    chk("zero.t.busy", 32'(busy), 0);
    nxt(); req0 = 0; smp();
    chk("zero.d.res_valid", 32'(res_valid), 1);
    chk("zero.d.res", 32'(res), 0);
    chk("zero.d.res_id", 32'(res_id), 0);
    chk("zero.d.busy", 32'(busy), 1);
    chk("zero.d.rdy0", 32'(din0_ready), 0);
    nxt(); smp();
    chk("zero.post.res_valid", 32'(res_valid), 0);
    chk("zero.post.busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_arbiter.md
ACC_ARBITER -- requirements
Module: acc_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, the sample and accumulator width.
REQ-002 The block SHALL have parameter LEN_W, default 8, the burst-length field width.
REQ-003 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port req0, input, 1, requester 0 burst request (level).
REQ-006 The block SHALL have port len0, input, LEN_W, requester 0 burst length in samples.
REQ-007 The block SHALL have port din0, input, DATA_W, requester 0 sample.
REQ-008 The block SHALL have port din0_valid, input, 1, requester 0 sample valid.
REQ-009 The block SHALL have port din0_ready, output, 1, requester 0 sample accepted when high with din0_valid.
REQ-010 The block SHALL have ports req1, len1, din1, din1_valid and din1_ready, identical to REQ-005..009, for requester 1.
REQ-011 The block SHALL have port res, output, DATA_W, burst sum.
REQ-012 The block SHALL have port res_valid, output, 1, one-cycle result strobe.
REQ-013 The block SHALL have port res_id, output, 1, requester owning res.
REQ-014 The block SHALL have port ovf, output, 1, unsigned carry-out seen during the burst.
REQ-015 The block SHALL have port busy, output, 1, high in RUN and DONE.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 req0/req1 SHALL be sampled only in IDLE; requests in RUN/DONE are ignored until IDLE is re-entered.
REQ-018 In IDLE, a single asserted request SHALL be granted; if both are asserted, the requester not granted last SHALL win.
REQ-019 The last-grant register SHALL reset to 1, so requester 0 wins the first tie.
REQ-020 On grant, the block SHALL latch owner id and len, clear the accumulator and ovf, and move to RUN (len != 0) or DONE (len == 0).
REQ-021 In RUN, din_ready of the owner SHALL be 1; din_ready of the non-owner SHALL be 0; both SHALL be 0 in IDLE and DONE.
REQ-022 Each owner beat (valid & ready) SHALL add din to the accumulator modulo 2^DATA_W and decrement the remaining count.
REQ-023 A carry-out on any beat SHALL set ovf, which stays set for the rest of the burst.
REQ-024 Cycles with owner valid low SHALL leave the accumulator and count unchanged.
REQ-025 Acceptance of the beat with remaining count 1 SHALL move RUN to DONE.
REQ-026 In DONE for exactly one cycle, res_valid SHALL be 1 with res = sum, res_id = owner and ovf = burst flag; the FSM then returns to IDLE.
REQ-027 res, res_id and ovf SHALL hold their values until the next DONE.
REQ-028 Latency with continuous valid SHALL be: grant at IDLE cycle t, beats in t+1..t+N, res_valid at t+N+1; len = 0 gives res = 0 with res_valid at t+1.
REQ-029 A requester holding req through res_valid SHALL be re-arbitrated in the following IDLE cycle, and SHALL lose a tie to the other requester.

Reset
REQ-030 Reset SHALL force IDLE, accumulator/res/count = 0, res_valid/res_id/ovf/busy/din0_ready/din1_ready = 0, and last-grant = 1.
REQ-031 Reset in any state, including mid-RUN, SHALL take effect at the next edge; the aborted burst produces no res_valid.

Verification
REQ-032 Reset held 2 cycles -> all outputs 0; after release with no req, busy stays 0.
REQ-033 req0 with len0=4 and din0 = 1,2,3,4 continuous -> res = 10, res_id = 0, ovf = 0, res_valid exactly one cycle at t+5.
REQ-034 req0 and req1 both asserted with len=2, din0 = 5,5, din1 = 7,7 -> first result 10 with id 0, then 14 with id 1; din1_ready = 0 throughout burst 0.
REQ-035 len0=2 with din0 = 0xFFFF, 0x0002 -> res = 0x0001, ovf = 1; the next burst with no carry -> ovf = 0.
REQ-036 len1=3 with din1_valid low for 2 cycles between beats (1,1,1) -> res = 3 and res_valid 2 cycles later than the continuous case.
REQ-037 Reset pulsed mid-RUN, and len0=0 -> no res_valid and outputs 0 the next cycle; then len0=0 -> res = 0 with res_valid one cycle after grant.
